// File: rtl/vend_if.sv
// Vending sequencer bus: coin slots, cancel, dispenser
// handshake, ejector and status lines.
interface vend_if #(
  parameter int W = 3
);
  logic [1:0]   coin_a;
  logic [1:0]   coin_b;
  logic         cancel;
  logic         disp_ack;
  logic         disp_req;
  logic         eject;
  logic         rej_a;
  logic         rej_b;
  logic [W-1:0] credit;
  logic         busy;
  logic         fault;

  modport master (
    input  coin_a, coin_b, cancel, disp_ack,
    output disp_req, eject, rej_a, rej_b,
    output credit, busy, fault
  );

  modport slave (
    output coin_a, coin_b, cancel, disp_ack,
    input  disp_req, eject, rej_a, rej_b,
    input  credit, busy, fault
  );
endinterface

// File: rtl/vend_sequencer.sv
// Vending controller: coin arbitration, credit,
// dispenser handshake with timeout, paced change ejection.
module vend_sequencer #(
  parameter int PRICE    = 3,
  parameter int MAX_CRED = 7,
  parameter int ACK_TO   = 16,
  parameter int EJ_GAP   = 2
) (
  input  logic  clk,
  input  logic  rst,
  vend_if.master bus
);
  localparam int W  = $clog2(MAX_CRED + 1);
  localparam int W1 = W + 1;
  localparam int TW = (ACK_TO > 1) ? $clog2(ACK_TO) : 1;
  localparam int GW = (EJ_GAP > 0) ? $clog2(EJ_GAP + 1) : 1;

  localparam logic [W1-1:0] CAP   = W1'(MAX_CRED);
  localparam logic [W1-1:0] PRC1  = W1'(PRICE);
  localparam logic [W-1:0]  PRC   = W'(PRICE);
  localparam logic [W-1:0]  ONE_W = W'(1);
  localparam logic [TW-1:0] TLAST = TW'(ACK_TO - 1);
  localparam logic [TW-1:0] ONE_T = TW'(1);
  localparam logic [GW-1:0] GAP   = GW'(EJ_GAP);
  localparam logic [GW-1:0] ONE_G = GW'(1);

  typedef enum logic [1:0] {
    ACCEPT   = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [W-1:0]  credit, credit_n;
  logic [TW-1:0] timer, timer_n;
  logic [GW-1:0] gap, gap_n;
  logic          ptr, ptr_n;

  logic          va, vb, take_a, take_b;
  logic [W1-1:0] add, sum;
  logic          ej_e, rej_a_e, rej_b_e, tmo_e;
  logic          req_n, busy_n;

  logic disp_req, eject, rej_a, rej_b, busy, fault;

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ACCEPT;
      credit   <= '0;
      timer    <= '0;
      gap      <= '0;
      ptr      <= 1'b0;
      disp_req <= 1'b0;
      eject    <= 1'b0;
      rej_a    <= 1'b0;
      rej_b    <= 1'b0;
      busy     <= 1'b0;
      fault    <= 1'b0;
    end else begin
      state    <= state_n;
      credit   <= credit_n;
      timer    <= timer_n;
      gap      <= gap_n;
      ptr      <= ptr_n;
      disp_req <= req_n;
      eject    <= ej_e;
      rej_a    <= rej_a_e;
      rej_b    <= rej_b_e;
      busy     <= busy_n;
      fault    <= tmo_e;
    end
  end

  // Next state, credit update, arbitration and pulse events
  always_comb begin
    state_n  = state;
    credit_n = credit;
    timer_n  = '0;
    gap_n    = gap;
    ptr_n    = ptr;
    ej_e     = 1'b0;
    rej_a_e  = 1'b0;
    rej_b_e  = 1'b0;
    tmo_e    = 1'b0;
    va       = (bus.coin_a == 2'b01) || (bus.coin_a == 2'b10);
    vb       = (bus.coin_b == 2'b01) || (bus.coin_b == 2'b10);
    take_a   = va && (!vb || !ptr);
    take_b   = vb && (!va || ptr);
    add      = '0;
    if (take_a) add = (bus.coin_a == 2'b10) ? W1'(2) : W1'(1);
    if (take_b) add = (bus.coin_b == 2'b10) ? W1'(2) : W1'(1);
    sum      = {1'b0, credit} + add;
    unique case (state)
      ACCEPT: begin
        rej_a_e = (bus.coin_a == 2'b11);
        rej_b_e = (bus.coin_b == 2'b11);
        if (va && vb) begin
          rej_a_e = ptr;
          rej_b_e = !ptr;
          ptr_n   = !ptr;
        end
        if ((take_a || take_b) && (sum > CAP)) begin
          rej_a_e = rej_a_e | take_a;
          rej_b_e = rej_b_e | take_b;
          if (bus.cancel && credit != '0) state_n = CHANGE;
        end else if (take_a || take_b) begin
          credit_n = sum[W-1:0];
          if (sum >= PRC1) state_n = DISPENSE;
        end else if (bus.cancel && credit != '0) begin
          state_n = CHANGE;
        end
      end
      DISPENSE: begin
        rej_a_e = |bus.coin_a;
        rej_b_e = |bus.coin_b;
        timer_n = timer + ONE_T;
        if (bus.disp_ack) begin
          credit_n = credit - PRC;
          timer_n  = '0;
          state_n  = (credit != PRC) ? CHANGE : ACCEPT;
        end else if (timer == TLAST) begin
          tmo_e   = 1'b1;
          timer_n = '0;
          state_n = CHANGE;
        end
      end
      CHANGE: begin
        rej_a_e = |bus.coin_a;
        rej_b_e = |bus.coin_b;
        if (gap != '0) begin
          gap_n = gap - ONE_G;
          if (gap == ONE_G && credit == '0) state_n = ACCEPT;
        end else if (credit != '0) begin
          ej_e     = 1'b1;
          credit_n = credit - ONE_W;
          gap_n    = GAP;
          if (GAP == '0 && credit == ONE_W) state_n = ACCEPT;
        end else begin
          state_n = ACCEPT;
        end
      end
      default: begin
        state_n = ACCEPT;
      end
    endcase
  end

  // Level outputs follow the state being entered
  always_comb begin
    req_n  = (state_n == DISPENSE);
    busy_n = (state_n != ACCEPT);
  end

  assign bus.disp_req = disp_req;
  assign bus.eject    = eject;
  assign bus.rej_a    = rej_a;
  assign bus.rej_b    = rej_b;
  assign bus.credit   = credit;
  assign bus.busy     = busy;
  assign bus.fault    = fault;
endmodule

// File: tb/tb_vend_sequencer.sv
// Bench for vend_sequencer: vector table, corner sequences,
// random traffic against a schedule-based reference model.
module tb_vend_sequencer;
  localparam int PRICE  = 3;
  localparam int MAXC   = 7;
  localparam int ACK_TO = 16;
  localparam int EJ_GAP = 2;
  localparam int W      = 3;

  typedef struct {
    logic [1:0] a;
    logic [1:0] b;
    logic       c;
    logic       k;
    logic [8:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  logic rst_hi;
  int   total = 0;
  int   bad = 0;
  vec_t tv[$];

  vend_if #(.W(W)) bus ();
  vend_if #(.W(W)) hb ();

  vend_sequencer #(
    .PRICE(PRICE), .MAX_CRED(MAXC),
    .ACK_TO(ACK_TO), .EJ_GAP(EJ_GAP)
  ) dut (.clk(clk), .rst(rst), .bus(bus));

  vend_sequencer #(
    .PRICE(7), .MAX_CRED(MAXC),
    .ACK_TO(ACK_TO), .EJ_GAP(EJ_GAP)
  ) dut_hi (.clk(clk), .rst(rst_hi), .bus(hb));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [8:0] o(int cr, bit rq, bit ej,
                                   bit ra, bit rb, bit bz, bit ft);
    return {3'(cr), rq, ej, ra, rb, bz, ft};
  endfunction

  function automatic logic [8:0] outs();
    return {bus.credit, bus.disp_req, bus.eject,
            bus.rej_a, bus.rej_b, bus.busy, bus.fault};
  endfunction

  function automatic logic [8:0] outs_hi();
    return {hb.credit, hb.disp_req, hb.eject,
            hb.rej_a, hb.rej_b, hb.busy, hb.fault};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic drive(logic [1:0] a, logic [1:0] b,
                       logic c, logic k);
    bus.coin_a   = a;
    bus.coin_b   = b;
    bus.cancel   = c;
    bus.disp_ack = k;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_hi(logic [1:0] a, logic c);
    hb.coin_a   = a;
    hb.coin_b   = 2'b00;
    hb.cancel   = c;
    hb.disp_ack = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic add(logic [1:0] a, logic [1:0] b,
                     logic c, logic k, logic [8:0] e);
    vec_t v;
    v.a = a;
    v.b = b;
    v.c = c;
    v.k = k;
    v.exp = e;
    tv.push_back(v);
  endtask

  // Reference model: credit as an integer, mode 0 idle /
  // 1 vending / 2 paying, payouts as a list of edge numbers.
  int         m_cred, m_mode, m_n, m_vs, m_end;
  int         m_credited, m_vends;
  bit         m_ptr;
  int         m_ej[$];
  logic [8:0] m_out;

  function automatic int cval(logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b10) return 2;
    return 0;
  endfunction

  task automatic m_reset();
    m_cred = 0;
    m_mode = 0;
    m_n = 0;
    m_vs = 0;
    m_end = 0;
    m_ptr = 1'b0;
    m_ej.delete();
    m_out = '0;
    m_credited = 0;
    m_vends = 0;
  endtask

  task automatic m_change();
    m_mode = 2;
    m_ej.delete();
    for (int i = 0; i < m_cred; i++)
      m_ej.push_back(m_n + 1 + i * (EJ_GAP + 1));
    m_end = m_n + 1 + (m_cred - 1) * (EJ_GAP + 1) + EJ_GAP;
  endtask

  task automatic m_step(logic [1:0] a, logic [1:0] b,
                        logic c, logic k);
    int wa, wb, win;
    bit sb, ej, ra, rb, ft;
    wa = cval(a);
    wb = cval(b);
    win = 0;
    sb = 0;
    ej = 0;
    ra = 0;
    rb = 0;
    ft = 0;
    m_n++;
    if (m_mode == 0) begin
      ra = (a == 2'b11);
      rb = (b == 2'b11);
      if (wa != 0 && wb != 0) begin
        sb = m_ptr;
        win = m_ptr ? wb : wa;
        if (m_ptr) ra = 1;
        else rb = 1;
        m_ptr = !m_ptr;
      end else if (wa != 0) begin
        win = wa;
      end else if (wb != 0) begin
        win = wb;
        sb = 1;
      end
      if (win != 0 && m_cred + win > MAXC) begin
        if (sb) rb = 1;
        else ra = 1;
        win = 0;
      end
      if (win != 0) begin
        m_cred += win;
        m_credited += win;
        if (m_cred >= PRICE) begin
          m_mode = 1;
          m_vs = m_n;
        end
      end else if (c && m_cred > 0) begin
        m_change();
      end
    end else begin
      ra = (a != 0);
      rb = (b != 0);
      if (m_mode == 1) begin
        if (k) begin
          m_cred -= PRICE;
          m_vends++;
          if (m_cred > 0) m_change();
          else m_mode = 0;
        end else if (m_n - m_vs == ACK_TO) begin
          ft = 1;
          m_change();
        end
      end else begin
        if (m_ej.size() > 0 && m_ej[0] == m_n) begin
          ej = 1;
          m_cred--;
          void'(m_ej.pop_front());
        end
        if (m_n == m_end) m_mode = 0;
      end
    end
    m_out = {3'(m_cred), m_mode == 1, ej, ra, rb,
             m_mode != 0, ft};
  endtask

  initial begin
    int ejk[$];
    int req_cnt, fk, cnt, obs_ej;
    logic [1:0] ra, rb;
    logic rc, rk;

    bus.coin_a = 0; bus.coin_b = 0;
    bus.cancel = 0; bus.disp_ack = 0;
    hb.coin_a = 0; hb.coin_b = 0;
    hb.cancel = 0; hb.disp_ack = 0;
    rst = 1'b1;
    rst_hi = 1'b1;
    #2;
    rst = 1'b0;
    rst_hi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_main", outs(), 0);
    chk("reset_hi", outs_hi(), 0);
    @(negedge clk);
    rst = 1'b1;
    rst_hi = 1'b1;

    add(2'b01, 2'b00, 0, 0, o(1, 0, 0, 0, 0, 0, 0));
    add(2'b10, 2'b00, 0, 0, o(3, 1, 0, 0, 0, 1, 0));
    add(2'b00, 2'b00, 0, 0, o(3, 1, 0, 0, 0, 1, 0));
    add(2'b00, 2'b00, 0, 1, o(0, 0, 0, 0, 0, 0, 0));
    add(2'b01, 2'b10, 0, 0, o(1, 0, 0, 0, 1, 0, 0));
    add(2'b01, 2'b10, 0, 0, o(3, 1, 0, 1, 0, 1, 0));
    add(2'b00, 2'b00, 0, 1, o(0, 0, 0, 0, 0, 0, 0));
    add(2'b00, 2'b10, 0, 0, o(2, 0, 0, 0, 0, 0, 0));
    add(2'b00, 2'b10, 0, 0, o(4, 1, 0, 0, 0, 1, 0));
    add(2'b00, 2'b00, 0, 1, o(1, 0, 0, 0, 0, 1, 0));
    add(2'b00, 2'b00, 0, 0, o(0, 0, 1, 0, 0, 1, 0));
    add(2'b00, 2'b00, 0, 0, o(0, 0, 0, 0, 0, 1, 0));
    add(2'b00, 2'b00, 0, 0, o(0, 0, 0, 0, 0, 0, 0));
    add(2'b11, 2'b00, 0, 0, o(0, 0, 0, 1, 0, 0, 0));
    add(2'b01, 2'b11, 0, 0, o(1, 0, 0, 0, 1, 0, 0));
    add(2'b00, 2'b00, 1, 0, o(1, 0, 0, 0, 0, 1, 0));
    add(2'b01, 2'b00, 0, 0, o(0, 0, 1, 1, 0, 1, 0));
    add(2'b00, 2'b00, 1, 0, o(0, 0, 0, 0, 0, 1, 0));
    add(2'b00, 2'b00, 0, 0, o(0, 0, 0, 0, 0, 0, 0));
    add(2'b00, 2'b00, 1, 0, o(0, 0, 0, 0, 0, 0, 0));
    add(2'b00, 2'b00, 0, 1, o(0, 0, 0, 0, 0, 0, 0));
    foreach (tv[i]) begin
      drive(tv[i].a, tv[i].b, tv[i].c, tv[i].k);
      chk($sformatf("vec%0d", i), outs(), tv[i].exp);
    end

    drive(2'b10, 2'b00, 0, 0);
    drive(2'b01, 2'b00, 0, 0);
    chk("t4_enter", outs(), o(3, 1, 0, 0, 0, 1, 0));
    req_cnt = int'(bus.disp_req);
    fk = 0;
    ejk.delete();
    for (int k = 1; k <= 40; k++) begin
      drive(2'b00, 2'b00, 0, 0);
      req_cnt += int'(bus.disp_req);
      if (bus.fault) fk = k;
      if (bus.eject) ejk.push_back(k);
    end
    chk("t4_req_cycles", req_cnt, ACK_TO);
    chk("t4_fault_at", fk, ACK_TO);
    chk("t4_ejects", ejk.size(), 3);
    chk("t4_first_ej", (ejk.size() > 0) ? ejk[0] : -1, ACK_TO + 1);
    chk("t4_spacing",
        (ejk.size() == 3) ? (ejk[1] - ejk[0]) * 10 + (ejk[2] - ejk[1]) : 0,
        (EJ_GAP + 1) * 11);
    chk("t4_end", outs(), 0);

    drive(2'b10, 2'b00, 0, 0);
    chk("t5_cred", outs(), o(2, 0, 0, 0, 0, 0, 0));
    drive(2'b00, 2'b00, 1, 0);
    chk("t5_cancel", outs(), o(2, 0, 0, 0, 0, 1, 0));
    drive(2'b00, 2'b01, 0, 0);
    chk("t5_coin_in_change", outs(), o(1, 0, 1, 0, 1, 1, 0));
    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      drive(2'b00, 2'b00, 0, 0);
      cnt += int'(bus.eject);
    end
    chk("t5_more_ejects", cnt, 1);
    chk("t5_end", outs(), 0);

    drive_hi(2'b10, 0);
    drive_hi(2'b10, 0);
    drive_hi(2'b10, 0);
    chk("t6_cred6", outs_hi(), o(6, 0, 0, 0, 0, 0, 0));
    drive_hi(2'b10, 0);
    chk("t6_overflow", outs_hi(), o(6, 0, 0, 1, 0, 0, 0));
    drive_hi(2'b00, 1);
    chk("t6_cancel", outs_hi(), o(6, 0, 0, 0, 0, 1, 0));
    drive_hi(2'b00, 0);
    chk("t6_ej1", outs_hi(), o(5, 0, 1, 0, 0, 1, 0));
    drive_hi(2'b00, 0);
    drive_hi(2'b00, 0);
    drive_hi(2'b00, 0);
    chk("t6_ej2", outs_hi(), o(4, 0, 1, 0, 0, 1, 0));
    #2;
    rst_hi = 1'b0;
    #1;
    chk("t6_async_reset", outs_hi(), 0);
    #2;
    rst_hi = 1'b1;
    drive_hi(2'b01, 0);
    chk("t6_after_reset", outs_hi(), o(1, 0, 0, 0, 0, 0, 0));

    drive(2'b01, 2'b00, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_drops_credit", outs(), 0);
    m_reset();
    @(negedge clk);
    rst = 1'b1;

    obs_ej = 0;
    for (int i = 0; i < 3000; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rb = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
      rc = ($urandom_range(0, 15) == 0);
      rk = ($urandom_range(0, 5) == 0);
      m_step(ra, rb, rc, rk);
      drive(ra, rb, rc, rk);
      obs_ej += int'(bus.eject);
      chk($sformatf("rand%0d", i), outs(), m_out);
    end
    for (int i = 0; i < 100; i++) begin
      if (m_mode == 0) break;
      m_step(2'b00, 2'b00, 1'b0, 1'b1);
      drive(2'b00, 2'b00, 1'b0, 1'b1);
      obs_ej += int'(bus.eject);
      chk($sformatf("drain%0d", i), outs(), m_out);
    end
    chk("drain_idle", m_mode, 0);
    chk("ledger", obs_ej, m_credited - PRICE * m_vends);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
